// File: rtl/step_seq_pkg.sv
// Shared types and constants for the T-step sequencer.
// Holds the FSM state encoding and step counter sizing.
package step_seq_pkg;

  localparam int MAX_STEPS = 8;
  localparam int STEP_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/step_decode.sv
// One-hot decoder for the active T-step index.
// Ports: idx (binary step index) in, onehot (bit i = Ti) out.
import step_seq_pkg::*;

module step_decode (
  input  logic [STEP_W-1:0]    idx,
  output logic [MAX_STEPS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/step_sequencer.sv
// T-step sequencer: walks T0..T(NUM_STEPS-1) per instruction on divider ticks.
// Ports: clock, clear (sync reset), tick, run, end_instr, halt in;
//   step (one-hot), step_idx, instr_done, running, halted out.
//   With SINGLE_STEP_EN defined, step_mode input adds single-step execution.
import step_seq_pkg::*;

module step_sequencer #(
  parameter int NUM_STEPS = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 tick,
  input  logic                 run,
  input  logic                 end_instr,
  input  logic                 halt,
`ifdef SINGLE_STEP_EN
  input  logic                 step_mode,
`endif
  output logic [MAX_STEPS-1:0] step,
  output logic [STEP_W-1:0]    step_idx,
  output logic                 instr_done,
  output logic                 running,
  output logic                 halted
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  state_t            state, state_n;
  logic [STEP_W-1:0] idx_n;
  logic              pend, pend_n;
  logic              done_n;
  logic              start_ok;
  logic              wrap_idle;
  logic              halt_req;

`ifdef SINGLE_STEP_EN
  logic run_prev;

  // In single-step mode a new instruction needs a fresh 0->1 on run
  // as seen across consecutive ticks.
  assign start_ok  = run && (!step_mode || !run_prev);
  assign wrap_idle = !run || step_mode;

  always_ff @(posedge clock) begin
    if (clear) begin
      run_prev <= 1'b0;
    end else if (tick) begin
      run_prev <= run;
    end
  end
`else
  assign start_ok  = run;
  assign wrap_idle = !run;
`endif

  // A halt seen this cycle counts as pending at a boundary in the same cycle.
  assign halt_req = pend || halt;

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      step_idx   <= '0;
      pend       <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_n;
      step_idx   <= idx_n;
      pend       <= pend_n;
      instr_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = step_idx;
    pend_n  = pend;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        pend_n = halt_req;
        if (tick) begin
          if (halt_req) begin
            state_n = ST_HALT;
            pend_n  = 1'b0;
          end else if (start_ok) begin
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        pend_n = halt_req;
        if (tick) begin
          if (end_instr || step_idx == LAST) begin
            idx_n  = '0;
            done_n = 1'b1;
            if (halt_req) begin
              state_n = ST_HALT;
              pend_n  = 1'b0;
            end else if (wrap_idle) begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = step_idx + 1'b1;
          end
        end
      end
      ST_HALT: begin
        pend_n = 1'b0;
        idx_n  = '0;
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALT);

  step_decode u_dec (
    .idx    (step_idx),
    .onehot (step)
  );

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer against a behavioural model.
// Directed scenarios followed by randomized traffic.
module tb_step_sequencer;

  localparam int N = 8;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic       end_instr = 1'b0;
  logic       halt = 1'b0;
  logic       smode = 1'b0;
  logic [7:0] step;
  logic [2:0] step_idx;
  logic       instr_done;
  logic       running;
  logic       halted;

  int tests = 0;
  int fails = 0;
  int done_cnt;

  // Model: mode 0 = idle, 1 = executing, 2 = halted
  int m_mode = 0;
  int m_t = 0;
  bit m_halt_req = 0;
  bit m_done = 0;
  bit m_prev_run = 0;

  step_sequencer #(.NUM_STEPS(N)) dut (
    .clock      (clock),
    .clear      (clear),
    .tick       (tick),
    .run        (run),
    .end_instr  (end_instr),
    .halt       (halt),
`ifdef SINGLE_STEP_EN
    .step_mode  (smode),
`endif
    .step       (step),
    .step_idx   (step_idx),
    .instr_done (instr_done),
    .running    (running),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  function automatic bit may_start();
    if (smode) return run && !m_prev_run;
    return run;
  endfunction

  task automatic model_edge();
    bit want_halt;
    bit last;
    want_halt = m_halt_req || (halt && m_mode != 2);
    m_done = 0;
    if (clear) begin
      m_mode = 0;
      m_t = 0;
      m_halt_req = 0;
      m_prev_run = 0;
      return;
    end
    m_halt_req = (m_mode == 2) ? 0 : want_halt;
    if (!tick) return;
    if (m_mode == 0) begin
      if (want_halt) begin
        m_mode = 2;
        m_halt_req = 0;
      end else if (may_start()) begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      last = end_instr || (m_t == N - 1);
      if (!last) begin
        m_t = m_t + 1;
      end else begin
        m_t = 0;
        m_done = 1;
        if (want_halt) begin
          m_mode = 2;
          m_halt_req = 0;
        end else if (!run || smode) begin
          m_mode = 0;
        end
      end
    end
    m_prev_run = run;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] oh;
    oh = 8'd1 << m_t;
    chk({tag, ".step"}, step, oh);
    chk({tag, ".idx"}, {5'd0, step_idx}, 8'(m_t));
    chk({tag, ".done"}, {7'd0, instr_done}, {7'd0, m_done});
    chk({tag, ".run"}, {7'd0, running}, {7'd0, m_mode == 1});
    chk({tag, ".halt"}, {7'd0, halted}, {7'd0, m_mode == 2});
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    if (instr_done) done_cnt++;
    check_all(tag);
  endtask

  // Three idle clocks then one tick clock.
  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick = 0;
      repeat (3) cyc(tag);
      tick = 1;
      cyc(tag);
      tick = 0;
    end
  endtask

  task automatic do_clear(input int n);
    clear = 1;
    repeat (n) cyc("clear");
    clear = 0;
  endtask

  initial begin
    // Reset
    clear = 1;
    repeat (2) cyc("rst");
    clear = 0;
    repeat (3) cyc("rst_idle");
    chk("rst_step_const", step, 8'h01);
    chk("rst_flags", {5'd0, running, halted, instr_done}, 8'h00);

    // Full-length instruction
    run = 1;
    ticks(1, "start");
    chk("start_run", {7'd0, running}, 8'h01);
    done_cnt = 0;
    ticks(N - 1, "full");
    chk("full_t7", step, 8'h80);
    ticks(1, "full_wrap");
    chk("full_done_cnt", 8'(done_cnt), 8'd1);
    chk("full_t0", step, 8'h01);

    // Early end at T3, plus end_instr without tick
    ticks(3, "early");
    chk("early_t3", step, 8'h08);
    end_instr = 1;
    repeat (3) cyc("ei_notick");
    chk("ei_hold", step, 8'h08);
    done_cnt = 0;
    tick = 1;
    cyc("early_wrap");
    tick = 0;
    end_instr = 0;
    cyc("early_after");
    chk("early_t0", step, 8'h01);
    chk("early_done_cnt", 8'(done_cnt), 8'd1);

    // Halt pulse at T2 between ticks
    ticks(2, "h_pre");
    cyc("h_mid");
    halt = 1;
    cyc("h_pulse");
    halt = 0;
    ticks(N - 3, "h_rest");
    chk("h_t7", step, 8'h80);
    ticks(1, "h_wrap");
    chk("h_halted", {7'd0, halted}, 8'h01);
    chk("h_step", step, 8'h01);
    end_instr = 1;
    ticks(4, "h_stuck");
    end_instr = 0;
    chk("h_still", {6'd0, halted, running}, 8'h02);

    // Mid-instruction clear coincident with tick
    do_clear(1);
    run = 1;
    ticks(6, "mid");
    chk("mid_t5", step, 8'h20);
    repeat (3) cyc("mid_gap");
    done_cnt = 0;
    clear = 1;
    tick = 1;
    cyc("mid_clr");
    clear = 0;
    tick = 0;
    run = 0;
    repeat (3) cyc("mid_post");
    chk("mid_idle", step, 8'h01);
    chk("mid_no_done", 8'(done_cnt), 8'd0);

    // Halt request while idle
    halt = 1;
    cyc("ih_req");
    halt = 0;
    ticks(1, "ih");
    chk("ih_halted", {7'd0, halted}, 8'h01);
    do_clear(2);

`ifdef SINGLE_STEP_EN
    smode = 1;
    run = 1;
    done_cnt = 0;
    ticks(N + 6, "ss1");
    chk("ss_one", 8'(done_cnt), 8'd1);
    chk("ss_idle", {7'd0, running}, 8'h00);
    run = 0;
    ticks(1, "ss_low");
    run = 1;
    ticks(N + 6, "ss2");
    chk("ss_two", 8'(done_cnt), 8'd2);
    smode = 0;
    do_clear(1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clear     = ($urandom_range(0, 199) == 0);
      tick      = ($urandom_range(0, 2) == 0);
      run       = ($urandom_range(0, 9) != 0);
      end_instr = ($urandom_range(0, 7) == 0);
      halt      = ($urandom_range(0, 59) == 0);
`ifdef SINGLE_STEP_EN
      smode     = ($urandom_range(0, 3) == 0);
`endif
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
